btn_event_queue: RTL and testbench
==================================

# btn_event_queue

Captures debounced button one-shot pulses as direction events in a small FIFO, raises a one-cycle interrupt for each accepted event and holds the oldest event for the CPU to read over MMIO. It sits between the four button debouncers and the OTTER interrupt input and IOBUS read mux. The CPU reads head, count and status, then writes an acknowledge to pop the head. Events the CPU has not serviced yet are queued rather than lost.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- CLK_50  in  1  50 MHz system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- BTN_PULSE  in  4  one-cycle debounced pulses; bit 0 up, 1 right, 2 down, 3 left.
- POP  in  1  one-cycle strobe; the wrapper drives it on an IOBUS write to the event-ack address.
- CLR_OVF  in  1  one-cycle strobe that clears OVERFLOW.
- EVT_CODE  out  2  direction code at the FIFO head (bit index of the button); 0 when empty.
- EVT_VALID  out  1  FIFO non-empty.
- EVT_COUNT  out  $clog2(DEPTH)+1  number of entries held.
- OVERFLOW  out  1  sticky flag: an event was dropped because the FIFO was full.
- INTR  out  1  one-cycle pulse for each accepted enqueue.

## Operation
- Candidate event: if any BTN_PULSE bit is set, the lowest set index is the candidate code.
  - Other bits set in the same cycle are discarded silently.
- Accept: the candidate is accepted unless the filter rejects it (see Configuration).
- Push: an accepted event is written at the write pointer and the write pointer increments modulo DEPTH.
- Pop: POP with the FIFO non-empty increments the read pointer modulo DEPTH. POP with the FIFO empty is ignored.
- EVT_COUNT is maintained as an explicit counter: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Full, push without pop: the event is dropped. OVERFLOW is set. INTR does not pulse. Pointers and count do not change.
- Full, push and pop together: both take effect, count stays DEPTH, OVERFLOW is not set, INTR pulses.
- Empty, push and pop together: the push takes effect and the pop is ignored (emptiness is judged before the edge). Count becomes 1.
- CLR_OVF and an overflow in the same cycle: the set wins and OVERFLOW stays 1.
- LAST_DIR (internal, 2 bits) updates to the code of every accepted event, including events dropped on full.

## Timing
- Reset values (asynchronous, while RST_N=0):
  - EVT_CODE=0, EVT_VALID=0, EVT_COUNT=0, OVERFLOW=0, INTR=0.
  - Pointers 0; LAST_DIR=1 (right, the snake's start heading).
- All outputs are registered or decoded from registers only. There is no combinational path from an input to an output.
- A pulse sampled at edge N appears on EVT_CODE, EVT_VALID and EVT_COUNT right after edge N. INTR is high for exactly the cycle following edge N.
- POP at edge N exposes the next entry (or EVT_VALID=0) right after edge N.
- Reset released mid-burst: events pending before reset are lost, and pulses present on the first clock edge after release are accepted.

## Configuration
- REVERSE_FILTER_EN defined: the candidate is rejected if its code equals LAST_DIR or equals LAST_DIR^2 (reversal).
  - A rejected candidate gives no push, no INTR, no OVERFLOW and no LAST_DIR update.
- REVERSE_FILTER_EN undefined: every candidate is accepted. LAST_DIR still updates but is unused.

## Test plan
- Reset, then BTN_PULSE=4'b0001 for one cycle -> next cycle EVT_VALID=1, EVT_CODE=0, EVT_COUNT=1, INTR=1 for one cycle; POP -> EVT_VALID=0, EVT_COUNT=0.
- DEPTH=4, without the filter: pulses 0,1,2,3,0 on separate cycles -> count saturates at 4, fifth pulse gives OVERFLOW=1 and only four INTR pulses. Pops return 0,1,2,3 in order. CLR_OVF -> OVERFLOW=0.
- FIFO full with BTN_PULSE=4'b0100 and POP in the same cycle -> EVT_COUNT stays 4, INTR=1, OVERFLOW=0, and code 2 is the last entry popped.
- FIFO empty with BTN_PULSE=4'b1010 and POP in the same cycle -> EVT_COUNT=1, EVT_CODE=1 (lowest bit wins), bit 3 discarded.
- REVERSE_FILTER_EN, after reset: pulse left (3) -> rejected, no INTR; pulse up (0) -> accepted; pulse down (2) -> rejected; pulse up (0) -> rejected; pulse right (1) -> accepted.
- Three entries queued, RST_N asserted low mid-cycle -> all outputs are 0 immediately without waiting for a clock edge. After release, the next pulse is accepted with EVT_COUNT=1.

Source files
------------

// File: rtl/btn_event_queue_if.sv
// Button event queue bus: pulse/ack/clear strobes in, head event and status out.
// DEPTH must match the btn_event_queue instance it connects to.
interface btn_event_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [3:0]       btn_pulse;
  logic             pop;
  logic             clr_ovf;
  logic [1:0]       evt_code;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic             intr;

  // Host side: debouncers and the MMIO wrapper
  modport master (
    output btn_pulse, pop, clr_ovf,
    input  evt_code, evt_valid, evt_count, overflow, intr
  );

  // Queue side
  modport slave (
    input  btn_pulse, pop, clr_ovf,
    output evt_code, evt_valid, evt_count, overflow, intr
  );
endinterface

// File: rtl/btn_event_queue.sv
// Queues debounced button pulses as 2-bit direction events for the CPU, with a
// one-cycle interrupt per accepted event. Optional macro REVERSE_FILTER_EN rejects
// repeats and reversals of the last accepted direction.
module btn_event_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic               CLK_50,
  input logic               RST_N,
  btn_event_queue_if.slave  bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [1:0]  DIR_RIGHT = 2'd1;

  // Storage and bookkeeping state
  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last_dir;

  // Registered outputs
  logic [1:0]       code_q;
  logic             valid_q;
  logic             ovf_q;
  logic             intr_q;

  // Next-state signals
  logic [1:0]       cand_code;
  logic             cand_valid;
  logic             accept;
  logic             full;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;
  logic [PTR_W-1:0] wr_nxt;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       last_nxt;
  logic [1:0]       code_nxt;
  logic             ovf_nxt;

  // Lowest set pulse bit is the candidate; the rest are dropped silently
  always_comb begin
    cand_code  = 2'd0;
    cand_valid = 1'b1;
    casez (bus.btn_pulse)
      4'b???1: cand_code = 2'd0;
      4'b??10: cand_code = 2'd1;
      4'b?100: cand_code = 2'd2;
      4'b1000: cand_code = 2'd3;
      default: cand_valid = 1'b0;
    endcase
  end

  always_comb begin
    accept = cand_valid;
`ifdef REVERSE_FILTER_EN
    // Repeating the current heading or reversing onto it is meaningless
    if ((cand_code == last_dir) || (cand_code == (last_dir ^ 2'd2)))
      accept = 1'b0;
`endif
  end

  always_comb begin
    wr_nxt   = wr_ptr;
    rd_nxt   = rd_ptr;
    cnt_nxt  = cnt;
    last_nxt = last_dir;
    code_nxt = 2'd0;
    ovf_nxt  = ovf_q;

    empty   = (cnt == CNT_W'(0));
    full    = (cnt == CNT_W'(DEPTH));
    pop_ok  = bus.pop && !empty;
    push_ok = accept && (!full || pop_ok);
    drop    = accept && full && !pop_ok;

    if (accept)
      last_nxt = cand_code;
    if (push_ok)
      wr_nxt = wr_ptr + PTR_W'(1);
    if (pop_ok)
      rd_nxt = rd_ptr + PTR_W'(1);

    unique case ({push_ok, pop_ok})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase

    // Head after the edge; the slot being written this cycle bypasses memory
    if (cnt_nxt != CNT_W'(0)) begin
      if (push_ok && (rd_nxt == wr_ptr))
        code_nxt = cand_code;
      else
        code_nxt = mem[rd_nxt];
    end

    // A same-cycle drop beats the clear
    if (drop)
      ovf_nxt = 1'b1;
    else if (bus.clr_ovf)
      ovf_nxt = 1'b0;
  end

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] <= 2'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      last_dir <= DIR_RIGHT;
      code_q   <= 2'd0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      if (push_ok)
        mem[wr_ptr] <= cand_code;
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      cnt      <= cnt_nxt;
      last_dir <= last_nxt;
      code_q   <= code_nxt;
      valid_q  <= (cnt_nxt != CNT_W'(0));
      ovf_q    <= ovf_nxt;
      intr_q   <= push_ok;
    end
  end

  assign bus.evt_code  = code_q;
  assign bus.evt_valid = valid_q;
  assign bus.evt_count = cnt;
  assign bus.overflow  = ovf_q;
  assign bus.intr      = intr_q;

endmodule

// File: tb/tb_btn_event_queue.sv
// Self-checking bench for btn_event_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_btn_event_queue;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  btn_event_queue_if #(.DEPTH(DEPTH)) bus ();

  btn_event_queue #(.DEPTH(DEPTH)) dut (
    .CLK_50 (clk),
    .RST_N  (rst_n),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  // Reference model state
  int q[$];
  bit m_ovf;
  bit m_intr;
  int m_last;

  function automatic void model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_intr = 1'b0;
    m_last = 1;
  endfunction

  function automatic void model_step(logic [3:0] b, bit p, bit c);
    int cand;
    bit acc;
    bit pop_ok;
    bit full;
    bit set_ovf;
    cand    = -1;
    set_ovf = 1'b0;
    for (int i = 0; i < 4; i++)
      if (b[i] && cand < 0) cand = i;
    acc = (cand >= 0);
`ifdef REVERSE_FILTER_EN
    if (acc && (cand == m_last || cand == (m_last ^ 2))) acc = 1'b0;
`endif
    pop_ok = p && (q.size() > 0);
    full   = (q.size() == DEPTH);
    m_intr = 1'b0;
    if (pop_ok) void'(q.pop_front());
    if (acc) begin
      m_last = cand;
      if (full && !pop_ok) set_ovf = 1'b1;
      else begin
        q.push_back(cand);
        m_intr = 1'b1;
      end
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endfunction

  // {valid, code, count, overflow, intr}
  function automatic logic [7:0] model_vec();
    logic [1:0] code;
    code = (q.size() > 0) ? 2'(q[0]) : 2'd0;
    return {q.size() > 0, code, 3'(q.size()), m_ovf, m_intr};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.evt_valid, bus.evt_code, bus.evt_count, bus.overflow, bus.intr};
  endfunction

  // One clock with the given strobes; returns #1 after the edge with inputs idle
  task automatic cycle(input logic [3:0] b, input logic p, input logic c);
    bus.btn_pulse = b;
    bus.pop       = p;
    bus.clr_ovf   = c;
    @(posedge clk);
    model_step(b, p, c);
    #1;
    bus.btn_pulse = 4'd0;
    bus.pop       = 1'b0;
    bus.clr_ovf   = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.btn_pulse = 4'd0;
    bus.pop       = 1'b0;
    bus.clr_ovf   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    rst_n = 1'b0;
    #3;
    obs = dut_vec();
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h", obs, 8'h00);
    end
    apply_reset();
    cycle(4'd0, 1'b0, 1'b0);
    obs = dut_vec();
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_idle: got %h required %h", obs, 8'h00);
    end
  endtask

  task automatic test_single();
    logic [7:0] obs;
    apply_reset();
    cycle(4'b0001, 1'b0, 1'b0);
    obs = dut_vec();
    n_checks++;
    if (obs !== {1'b1, 2'd0, 3'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL single_push: got %h required %h", obs, {1'b1, 2'd0, 3'd1, 1'b0, 1'b1});
    end
    cycle(4'd0, 1'b0, 1'b0);
    obs = dut_vec();
    n_checks++;
    if (obs !== {1'b1, 2'd0, 3'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL single_intr_once: got %h required %h", obs, {1'b1, 2'd0, 3'd1, 1'b0, 1'b0});
    end
    cycle(4'd0, 1'b1, 1'b0);
    obs = dut_vec();
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL single_pop: got %h required %h", obs, 8'h00);
    end
    cycle(4'd0, 1'b1, 1'b0);
    obs = dut_vec();
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL pop_empty: got %h required %h", obs, 8'h00);
    end
  endtask

`ifndef REVERSE_FILTER_EN
  task automatic test_fill_overflow();
    logic [7:0] obs;
    logic [3:0] pulses [5];
    int n_intr;
    pulses = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n_intr = 0;
    apply_reset();
    foreach (pulses[i]) begin
      cycle(pulses[i], 1'b0, 1'b0);
      n_intr += int'(bus.intr);
    end
    obs = dut_vec();
    n_checks++;
    if (obs !== {1'b1, 2'd0, 3'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL fill_overflow: got %h required %h", obs, {1'b1, 2'd0, 3'd4, 1'b1, 1'b0});
    end
    n_checks++;
    if (n_intr !== 4) begin
      n_fail++;
      $display("FAIL fill_intr_count: got %0d required %0d", n_intr, 4);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.evt_code !== 2'(i) || bus.evt_count !== 3'(4 - i)) begin
        n_fail++;
        $display("FAIL pop_order_%0d: got code %0d count %0d required code %0d count %0d",
                 i, bus.evt_code, bus.evt_count, i, 4 - i);
      end
      cycle(4'd0, 1'b1, 1'b0);
    end
    obs = dut_vec();
    n_checks++;
    if (obs !== {1'b0, 2'd0, 3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL drained: got %h required %h", obs, {1'b0, 2'd0, 3'd0, 1'b1, 1'b0});
    end
    cycle(4'd0, 1'b0, 1'b1);
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ovf: got %b required %b", bus.overflow, 1'b0);
    end
    // Refill then overflow and clear in the same cycle: the set must win
    for (int i = 0; i < 4; i++) cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b1);
    obs = dut_vec();
    n_checks++;
    if (obs !== {1'b1, 2'd3, 3'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_set_beats_clr: got %h required %h", obs, {1'b1, 2'd3, 3'd4, 1'b1, 1'b0});
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] obs;
    apply_reset();
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0);
    obs = dut_vec();
    n_checks++;
    if (obs !== {1'b1, 2'd1, 3'd4, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL full_push_pop: got %h required %h", obs, {1'b1, 2'd1, 3'd4, 1'b0, 1'b1});
    end
    repeat (3) cycle(4'd0, 1'b1, 1'b0);
    obs = dut_vec();
    n_checks++;
    if (obs !== {1'b1, 2'd2, 3'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL full_push_pop_tail: got %h required %h", obs, {1'b1, 2'd2, 3'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_empty_push_pop();
    logic [7:0] obs;
    apply_reset();
    cycle(4'b1010, 1'b1, 1'b0);
    obs = dut_vec();
    n_checks++;
    if (obs !== {1'b1, 2'd1, 3'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL empty_push_pop: got %h required %h", obs, {1'b1, 2'd1, 3'd1, 1'b0, 1'b1});
    end
  endtask
`endif

`ifdef REVERSE_FILTER_EN
  task automatic test_filter();
    logic [3:0] pulses [5];
    logic       want_intr [5];
    pulses    = '{4'b1000, 4'b0001, 4'b0100, 4'b0001, 4'b0010};
    want_intr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    foreach (pulses[i]) begin
      cycle(pulses[i], 1'b0, 1'b0);
      n_checks++;
      if (bus.intr !== want_intr[i] || bus.overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL filter_step_%0d: got intr %b ovf %b required intr %b ovf 0",
                 i, bus.intr, bus.overflow, want_intr[i]);
      end
    end
    n_checks++;
    if (bus.evt_count !== 3'd2 || bus.evt_code !== 2'd0) begin
      n_fail++;
      $display("FAIL filter_contents: got count %0d code %0d required count 2 code 0",
               bus.evt_count, bus.evt_code);
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [7:0] obs;
    apply_reset();
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    n_checks++;
    if (bus.evt_count !== 3'd3) begin
      n_fail++;
      $display("FAIL async_prefill: got count %0d required 3", bus.evt_count);
    end
    #3;
    rst_n = 1'b0;
    #1;
    obs = dut_vec();
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got %h required %h", obs, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(4'b0001, 1'b0, 1'b0);
    obs = dut_vec();
    n_checks++;
    if (obs !== {1'b1, 2'd0, 3'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset_push: got %h required %h", obs, {1'b1, 2'd0, 3'd1, 1'b0, 1'b1});
    end
  endtask

  task automatic test_random();
    logic [7:0] obs;
    logic [7:0] exp;
    logic [3:0] b;
    logic       p;
    logic       c;
    int         errs;
    errs = 0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      p = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 15) == 0);
      cycle(b, p, c);
      obs = dut_vec();
      exp = model_vec();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle_%0d: got %h required %h (btn %b pop %b clr %b)",
                   i, obs, exp, b, p, c);
      end
    end
  endtask

  initial begin
    bus.btn_pulse = 4'd0;
    bus.pop       = 1'b0;
    bus.clr_ovf   = 1'b0;
    model_reset();
    test_reset();
    test_single();
`ifndef REVERSE_FILTER_EN
    test_fill_overflow();
    test_full_push_pop();
    test_empty_push_pop();
`else
    test_filter();
`endif
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
